// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and pipeline depth helper for the
// pipelined carry-lookahead adder.
package alu_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    // One pipeline stage per lookahead group.
    function automatic int nstg(input int width, input int block);
        return width / block;
    endfunction

endpackage

// File: rtl/cla_group.sv
// One BLOCK-wide carry-lookahead group: flattened sum-of-products carries,
// no ripple between bit positions.
module cla_group #(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;

    function automatic logic all_prop(input logic [BLOCK-1:0] pv, input int hi, input int lo);
        logic r;
        r = 1'b1;
        for (int k = lo; k <= hi; k++) begin
            r = r & pv[k];
        end
        return r;
    endfunction

    // Each c[i+1] is built only from g, p and cin, never from a lower c[j].
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BLOCK; i++) begin
            c[i+1] = g[i] | (all_prop(p, i, 0) & cin);
            for (int j = 0; j < i; j++) begin
                c[i+1] = c[i+1] | (all_prop(p, i, j + 1) & g[j]);
            end
        end
    end

    assign s     = p ^ c[BLOCK-1:0];
    assign cout  = c[BLOCK];
    assign c_msb = c[BLOCK-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one lookahead group per stage,
// valid/ready handshake with full back-pressure, sum/cout/ovf/zero results.
module cla_pipe_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int NSTG = nstg(WIDTH, BLOCK);

    logic             vld_q  [NSTG];
    logic [WIDTH-1:0] a_q    [NSTG];
    logic [WIDTH-1:0] b_q    [NSTG];
    logic [WIDTH-1:0] sum_q  [NSTG];
    logic             cin_q  [NSTG];
    logic             zero_q [NSTG];

    logic [WIDTH-1:0] sum_d    [NSTG];
    logic [BLOCK-1:0] grp_s    [NSTG];
    logic             grp_cout [NSTG];
    logic             grp_cmsb [NSTG];

    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_cout_q;
    logic             out_ovf_q;
    logic             out_zero_q;
    logic             adv;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        cla_group #(.BLOCK(BLOCK)) u_grp (
            .a     (a_q[k][k*BLOCK +: BLOCK]),
            .b     (b_q[k][k*BLOCK +: BLOCK]),
            .cin   (cin_q[k]),
            .s     (grp_s[k]),
            .cout  (grp_cout[k]),
            .c_msb (grp_cmsb[k])
        );
    end

    always_comb begin
        for (int k = 0; k < NSTG; k++) begin
            sum_d[k]                    = sum_q[k];
            sum_d[k][k*BLOCK +: BLOCK] = grp_s[k];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // its predecessor's pre-edge value, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NSTG; k++) begin
                vld_q[k] <= 1'b0;
            end
            out_valid_q <= 1'b0;
        end else if (adv) begin
            vld_q[0] <= in_valid;
            for (int k = 1; k < NSTG; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
            out_valid_q <= vld_q[NSTG-1];
        end
    end

    // NOTE: datapath registers carry no reset; only the valid bits qualify them,
    // and the output ports are masked while out_valid is low.
    always_ff @(posedge clock) begin
        if (adv) begin
            a_q[0]    <= in_a;
            b_q[0]    <= (in_sub == SUB) ? ~in_b : in_b;
            cin_q[0]  <= (in_sub != ADD);
            sum_q[0]  <= '0;
            zero_q[0] <= 1'b1;
            for (int k = 1; k < NSTG; k++) begin
                a_q[k]    <= a_q[k-1];
                b_q[k]    <= b_q[k-1];
                cin_q[k]  <= grp_cout[k-1];
                sum_q[k]  <= sum_d[k-1];
                zero_q[k] <= zero_q[k-1] & ~|grp_s[k-1];
            end
            out_sum_q  <= sum_d[NSTG-1];
            out_cout_q <= grp_cout[NSTG-1];
            out_ovf_q  <= grp_cout[NSTG-1] ^ grp_cmsb[NSTG-1];
            out_zero_q <= zero_q[NSTG-1] & ~|grp_s[NSTG-1];
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_valid_q ? out_sum_q : '0;
    assign out_cout  = out_valid_q & out_cout_q;
    assign out_ovf   = out_valid_q & out_ovf_q;
    assign out_zero  = out_valid_q & out_zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed corner cases, stalls, reset
// with operations in flight, and a width/group parametrisation sweep.
module tb_cla_pipe_adder;

    localparam int W = 32;
    localparam int B = 8;
    localparam int N = W / B;
    localparam int SW_W [3] = '{16, 32, 64};
    localparam int SW_B [3] = '{4, 32, 8};

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct packed {
        res_t r;
        int   acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, in_sub, out_valid, out_ready;
    logic out_cout, out_ovf, out_zero;
    logic [W-1:0] in_a, in_b, out_sum;

    logic        sw_valid, sw_sub;
    logic [63:0] sw_a, sw_b;
    logic [15:0] s16;
    logic [31:0] s32;
    logic [63:0] s64;
    logic [2:0]  sw_rdy, sw_ov, sw_co, sw_of, sw_z;
    logic [63:0] sw_sum [3];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cla_pipe_adder #(.WIDTH(W), .BLOCK(B)) u_dut (
        .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
        .out_ovf(out_ovf), .out_zero(out_zero)
    );

    cla_pipe_adder #(.WIDTH(16), .BLOCK(4)) u_sw16 (
        .clock(clk), .reset(rst), .in_valid(sw_valid), .in_ready(sw_rdy[0]),
        .in_a(sw_a[15:0]), .in_b(sw_b[15:0]), .in_sub(sw_sub), .out_valid(sw_ov[0]),
        .out_ready(1'b1), .out_sum(s16), .out_cout(sw_co[0]),
        .out_ovf(sw_of[0]), .out_zero(sw_z[0])
    );

    cla_pipe_adder #(.WIDTH(32), .BLOCK(32)) u_sw32 (
        .clock(clk), .reset(rst), .in_valid(sw_valid), .in_ready(sw_rdy[1]),
        .in_a(sw_a[31:0]), .in_b(sw_b[31:0]), .in_sub(sw_sub), .out_valid(sw_ov[1]),
        .out_ready(1'b1), .out_sum(s32), .out_cout(sw_co[1]),
        .out_ovf(sw_of[1]), .out_zero(sw_z[1])
    );

    cla_pipe_adder #(.WIDTH(64), .BLOCK(8)) u_sw64 (
        .clock(clk), .reset(rst), .in_valid(sw_valid), .in_ready(sw_rdy[2]),
        .in_a(sw_a), .in_b(sw_b), .in_sub(sw_sub), .out_valid(sw_ov[2]),
        .out_ready(1'b1), .out_sum(s64), .out_cout(sw_co[2]),
        .out_ovf(sw_of[2]), .out_zero(sw_z[2])
    );

    always_comb begin
        sw_sum[0] = {48'd0, s16};
        sw_sum[1] = {32'd0, s32};
        sw_sum[2] = s64;
    end

    // Reference: plain unsigned/signed arithmetic on w-bit operands.
    function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic sub);
        logic [64:0]        m, ua, ub, t;
        logic signed [66:0] half, sa, sb, tr;
        res_t r;
        m      = (65'd1 << w) - 65'd1;
        ua     = {1'b0, a} & m;
        ub     = {1'b0, b} & m;
        t      = sub ? ua - ub : ua + ub;
        r.sum  = t[63:0] & m[63:0];
        r.cout = sub ? (ua >= ub) : ((t >> w) != 65'd0);
        half   = 67'sd1 <<< (w - 1);
        sa     = $signed({2'b00, ua});
        sa     = (sa ^ half) - half;
        sb     = $signed({2'b00, ub});
        sb     = (sb ^ half) - half;
        tr     = sub ? sa - sb : sa + sb;
        r.ovf  = (tr >= half) || (tr < -half);
        r.zero = (r.sum == 64'd0);
        return r;
    endfunction

    function automatic res_t observed();
        res_t r;
        r.sum  = {32'd0, out_sum};
        r.cout = out_cout;
        r.ovf  = out_ovf;
        r.zero = out_zero;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one op to the idle main DUT and wait (bounded) for its result.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          output res_t r, output int lat, output logic rdy);
        tick();
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        out_ready = 1'b1;
        @(negedge clk);
        rdy = in_ready;
        tick();
        in_valid = 1'b0;
        lat      = -1;
        r        = '0;
        for (int n = 0; n <= 40; n++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = n;
                r   = observed();
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
        sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_sub = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_sum !== '0) begin n_bad++; $display("FAIL reset_out_sum: got %h want 0", out_sum); end
        n_cmp++; if ({out_cout, out_ovf, out_zero} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags: got c/v/z=%b%b%b want 000", out_cout, out_ovf, out_zero);
        end
        n_cmp++; if (sw_ov !== 3'b000) begin n_bad++; $display("FAIL reset_sweep_valid: got %b want 000", sw_ov); end
    endtask

    task automatic test_directed();
        logic [31:0] va [4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd5};
        logic [31:0] vb [4] = '{32'd1, 32'd1, 32'd1, 32'd5};
        logic        vs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] es [4] = '{32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 32'd0};
        logic [2:0]  ef [4] = '{3'b010, 3'b101, 3'b110, 3'b101};
        res_t r;
        int   lat;
        logic rdy;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vs[i], r, lat, rdy);
            n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL dir%0d_in_ready: got %b want 1", i, rdy); end
            n_cmp++; if (lat != N) begin n_bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, N); end
            n_cmp++; if (r.sum[31:0] !== es[i]) begin
                n_bad++; $display("FAIL dir%0d_sum: got %h want %h", i, r.sum[31:0], es[i]);
            end
            n_cmp++; if ({r.cout, r.ovf, r.zero} !== ef[i]) begin
                n_bad++; $display("FAIL dir%0d_flags: got c/v/z=%b%b%b want %b", i, r.cout, r.ovf, r.zero, ef[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t        q [$];
        res_t        obs;
        int          sent = 0;
        int          got  = 0;
        logic        exp_rdy;
        logic [31:0] pa, pb;
        logic        ps;
        pa = $urandom; pb = $urandom; ps = 1'($urandom_range(0, 1));
        for (int c = 0; c < 60 && got < 8; c++) begin
            tick();
            exp_rdy   = !(c >= 6 && c <= 8);
            out_ready = exp_rdy;
            in_valid  = (sent < 8);
            in_a = pa; in_b = pb; in_sub = ps;
            @(negedge clk);
            n_cmp++; if (in_ready !== exp_rdy) begin
                n_bad++; $display("FAIL b2b_in_ready c=%0d: got %b want %b", c, in_ready, exp_rdy);
            end
            if (out_valid === 1'b1) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL b2b_extra_result c=%0d: got sum=%h want none", c, out_sum);
                end else begin
                    obs = observed();
                    if (obs !== q[0]) begin
                        n_bad++;
                        $display("FAIL b2b_result c=%0d: got sum=%h c/v/z=%b%b%b want sum=%h c/v/z=%b%b%b",
                                 c, obs.sum[31:0], obs.cout, obs.ovf, obs.zero,
                                 q[0].sum[31:0], q[0].cout, q[0].ovf, q[0].zero);
                    end
                    if (out_ready) begin
                        void'(q.pop_front());
                        got++;
                    end
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                q.push_back(model(W, {32'd0, pa}, {32'd0, pb}, ps));
                sent++;
                pa = $urandom; pb = $urandom; ps = 1'($urandom_range(0, 1));
            end
        end
        n_cmp++; if (got != 8) begin n_bad++; $display("FAIL b2b_count: got %0d want 8", got); end
        n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL b2b_leftover: got %0d want 0", q.size()); end
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset_inflight();
        int          stale = 0;
        res_t        r, e;
        int          lat;
        logic        rdy;
        logic [31:0] a, b;
        logic        s;
        for (int c = 0; c < 3; c++) begin
            tick();
            in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_sub = 1'($urandom_range(0, 1));
            out_ready = 1'b1;
        end
        tick();
        rst = 1'b1; in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_flight_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_flight_in_ready: got %b want 1", in_ready); end
        repeat (10) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        n_cmp++; if (stale != 0) begin n_bad++; $display("FAIL rst_flight_stale: got %0d stale cycles want 0", stale); end
        a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
        e = model(W, {32'd0, a}, {32'd0, b}, s);
        run_op(a, b, s, r, lat, rdy);
        n_cmp++; if (lat != N) begin n_bad++; $display("FAIL rst_flight_latency: got %0d want %0d", lat, N); end
        n_cmp++; if (r !== e) begin
            n_bad++; $display("FAIL rst_flight_result: got sum=%h c/v/z=%b%b%b want sum=%h c/v/z=%b%b%b",
                              r.sum[31:0], r.cout, r.ovf, r.zero, e.sum[31:0], e.cout, e.ovf, e.zero);
        end
    endtask

    task automatic test_param_sweep();
        exp_t qs [3][$];
        exp_t e;
        res_t obs;
        for (int c = 0; c < 80; c++) begin
            tick();
            sw_valid = (c < 60) && ($urandom_range(0, 3) != 0);
            sw_a     = {$urandom, $urandom};
            sw_b     = {$urandom, $urandom};
            sw_sub   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                sw_a = '1; sw_b = 64'd1; sw_sub = 1'b0;
            end
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (sw_ov[i] === 1'b1) begin
                    n_cmp++;
                    if (qs[i].size() == 0) begin
                        n_bad++; $display("FAIL sweep_extra W=%0d: got sum=%h want none", SW_W[i], sw_sum[i]);
                    end else begin
                        e        = qs[i].pop_front();
                        obs.sum  = sw_sum[i];
                        obs.cout = sw_co[i];
                        obs.ovf  = sw_of[i];
                        obs.zero = sw_z[i];
                        if (obs !== e.r) begin
                            n_bad++;
                            $display("FAIL sweep_result W=%0d B=%0d: got sum=%h c/v/z=%b%b%b want sum=%h c/v/z=%b%b%b",
                                     SW_W[i], SW_B[i], obs.sum, obs.cout, obs.ovf, obs.zero,
                                     e.r.sum, e.r.cout, e.r.ovf, e.r.zero);
                        end
                        n_cmp++;
                        if (cyc - e.acc != SW_W[i] / SW_B[i]) begin
                            n_bad++; $display("FAIL sweep_latency W=%0d B=%0d: got %0d want %0d",
                                              SW_W[i], SW_B[i], cyc - e.acc, SW_W[i] / SW_B[i]);
                        end
                    end
                end
            end
            if (sw_valid) begin
                for (int i = 0; i < 3; i++) begin
                    n_cmp++; if (sw_rdy[i] !== 1'b1) begin
                        n_bad++; $display("FAIL sweep_in_ready W=%0d: got %b want 1", SW_W[i], sw_rdy[i]);
                    end
                    qs[i].push_back('{r: model(SW_W[i], sw_a, sw_b, sw_sub), acc: cyc + 1});
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (qs[i].size() != 0) begin
                n_bad++; $display("FAIL sweep_leftover W=%0d: got %0d want 0", SW_W[i], qs[i].size());
            end
        end
        sw_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_inflight();
        test_param_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
